// File: rtl/cla_multiword_seq_pkg.sv
// Shared word width and sequencer state encoding for the multi-word CLA sequencer.
package cla_multiword_seq_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/CLA_16.sv
// 16-bit carry-lookahead adder slice: four 4-bit groups with group generate/propagate.
module CLA_16 (
  input  logic [15:0] X,
  input  logic [15:0] Y,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  bc;

  always_comb begin
    g  = X & Y;
    p  = X ^ Y;
    c  = '0;
    gg = '0;
    gp = '0;
    bc = '0;
    for (int b = 0; b < 4; b++) begin
      gg[b] = g[4*b+3] | (p[4*b+3] & g[4*b+2]) | (p[4*b+3] & p[4*b+2] & g[4*b+1])
            | (p[4*b+3] & p[4*b+2] & p[4*b+1] & g[4*b]);
      gp[b] = &p[4*b +: 4];
    end
    // Group carries resolve from group terms; bit carries only ripple inside a group.
    bc[0] = Cin;
    for (int b = 0; b < 4; b++) begin
      bc[b+1] = gg[b] | (gp[b] & bc[b]);
    end
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) c[i] = bc[i/4];
      else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    S    = p ^ c;
    Cout = bc[4];
  end

endmodule

// File: rtl/cla_multiword_seq.sv
// Multi-word add/subtract sequencer: one CLA_16 slice reused LS word first, carry chained
// through a register, valid/ready handshakes on operand and result sides.
module cla_multiword_seq
  import cla_multiword_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      op_sub,
  input  logic [WORD_W*WORDS-1:0]   A,
  input  logic [WORD_W*WORDS-1:0]   B,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   S,
  output logic                      cout,
  output logic                      ovf,
  output logic                      zero,
  output logic                      busy
);

  localparam int unsigned TOT_W = WORD_W * WORDS;
  localparam int unsigned IDX_W = $clog2(WORDS);

  state_e             state_q;
  state_e             state_d;
  logic [TOT_W-1:0]   a_q;
  logic [TOT_W-1:0]   b_q;
  logic               sub_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;

  logic [31:0]        base_c;
  logic [WORD_W-1:0]  x_c;
  logic [WORD_W-1:0]  y_c;
  logic [WORD_W-1:0]  sum_c;
  logic               slice_cout_c;
  logic [TOT_W-1:0]   s_full_c;
  logic               last_c;
  logic               ovf_c;
  logic               accept_c;

  CLA_16 u_slice (
    .X    (x_c),
    .Y    (y_c),
    .Cin  (carry_q),
    .S    (sum_c),
    .Cout (slice_cout_c)
  );

  // Word selection and flag terms for the current RUN step
  always_comb begin
    base_c   = 32'(idx_q) * WORD_W;
    x_c      = a_q[base_c +: WORD_W];
    y_c      = b_q[base_c +: WORD_W] ^ {WORD_W{sub_q}};
    s_full_c = S;
    s_full_c[base_c +: WORD_W] = sum_c;
    last_c   = (idx_q == IDX_W'(WORDS - 1));
    ovf_c    = (x_c[WORD_W-1] == y_c[WORD_W-1]) && (sum_c[WORD_W-1] != x_c[WORD_W-1]);
    accept_c = in_valid && (state_q == ST_IDLE);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c)  state_d = ST_RUN;
      ST_RUN:  if (last_c)    state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake/status outputs are registered copies of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      S       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else if (accept_c) begin
      a_q     <= A;
      b_q     <= B;
      sub_q   <= op_sub;
      idx_q   <= '0;
      carry_q <= op_sub;
    end else if (state_q == ST_RUN) begin
      S       <= s_full_c;
      carry_q <= slice_cout_c;
      idx_q   <= idx_q + IDX_W'(1);
      if (last_c) begin
        cout <= slice_cout_c;
        ovf  <= ovf_c;
        zero <= (s_full_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed bench for cla_multiword_seq with WORDS=4 (64-bit operands).
module tb_cla_multiword_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [63:0] A;
  logic [63:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] S;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  cla_multiword_seq #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Issue one operation from IDLE, scramble inputs after accept, wait for out_valid.
  // lat counts rising edges from the accept edge (inclusive) to out_valid seen high.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        output int lat);
    A = a; B = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = a ^ b ^ 64'h5A5A_A5A5_3C3C_C3C3; op_sub = ~sub;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; A = '0; B = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({S, cout, ovf, zero} !== 67'd0) begin
      bad++; $display("FAIL reset_result S=%h cout=%b ovf=%b zero=%b exp all 0", S, cout, ovf, zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry();
    int lat;
    run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL add_latency got=%0d exp=5", lat); end
    total++; if (S !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL add_s got=%h exp=0000000100000000", S); end
    total++; if ({cout, ovf, zero} !== 3'b000) begin bad++; $display("FAIL add_flags got=%b%b%b exp=000", cout, ovf, zero); end
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL add_done_status in_ready=%b busy=%b exp 0/1", in_ready, busy);
    end
    release_out();
  endtask

  task automatic test_wrap();
    int lat;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    total++; if (S !== 64'h0) begin bad++; $display("FAIL wrap_s got=%h exp=0", S); end
    total++; if ({cout, ovf, zero} !== 3'b101) begin bad++; $display("FAIL wrap_flags got=%b%b%b exp=101", cout, ovf, zero); end
    release_out();
  endtask

  task automatic test_sub();
    int lat;
    run_op(64'd5, 64'd7, 1'b1, lat);
    total++; if (S !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL sub_borrow_s got=%h exp=fffffffffffffffe", S); end
    total++; if ({cout, ovf, zero} !== 3'b000) begin bad++; $display("FAIL sub_borrow_flags got=%b%b%b exp=000", cout, ovf, zero); end
    release_out();
    run_op(64'd7, 64'd5, 1'b1, lat);
    total++; if (S !== 64'd2) begin bad++; $display("FAIL sub_s got=%h exp=2", S); end
    total++; if ({cout, ovf, zero} !== 3'b100) begin bad++; $display("FAIL sub_flags got=%b%b%b exp=100", cout, ovf, zero); end
    release_out();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    total++; if (S !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_add_s got=%h exp=8000000000000000", S); end
    total++; if ({cout, ovf, zero} !== 3'b010) begin bad++; $display("FAIL ovf_add_flags got=%b%b%b exp=010", cout, ovf, zero); end
    release_out();
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, lat);
    total++; if (S !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL ovf_sub_s got=%h exp=7fffffffffffffff", S); end
    total++; if ({cout, ovf, zero} !== 3'b110) begin bad++; $display("FAIL ovf_sub_flags got=%b%b%b exp=110", cout, ovf, zero); end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    int errs;
    run_op(64'h0000_0000_0000_1234, 64'h0000_0000_0000_1111, 1'b0, lat);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      A = {$urandom, $urandom}; B = {$urandom, $urandom}; in_valid = 1'(i % 2); op_sub = 1'(i % 3 == 0);
      @(posedge clk); #1;
      if (S !== 64'h2345 || {cout, ovf, zero} !== 3'b000 || out_valid !== 1'b1 || in_ready !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin
      bad++; $display("FAIL backpressure_hold cycles_changed=%0d exp=0 (S=%h ov=%b ir=%b)", errs, S, out_valid, in_ready);
    end
    in_valid = 1'b0;
    release_out();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL backpressure_release ov=%b ir=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    int e1;
    logic acc;
    e0 = -1; e1 = -1;
    A = 64'd1; B = 64'd2; op_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin
        if (e0 < 0) e0 = i;
        else if (e1 < 0) e1 = i;
      end
    end
    in_valid = 1'b0;
    total++; if (e1 - e0 !== 6) begin bad++; $display("FAIL throughput_period got=%0d exp=6", e1 - e0); end
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++; if (S !== 64'd3 || busy !== 1'b0) begin bad++; $display("FAIL throughput_result S=%h busy=%b exp 3/0", S, busy); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h1; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrun_reset ov=%b busy=%b ir=%b exp 0/0/1", out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(64'h0000_0000_0000_DDDD, 64'h0000_0000_0000_0022, 1'b0, lat);
    total++; if (S !== 64'h0000_0000_0000_DDFF) begin bad++; $display("FAIL post_reset_s got=%h exp=000000000000ddff", S); end
    total++; if ({cout, ovf, zero} !== 3'b000 || lat !== 5) begin
      bad++; $display("FAIL post_reset_flags got=%b%b%b lat=%0d exp=000 lat=5", cout, ovf, zero, lat);
    end
    release_out();
  endtask

  task automatic test_reset_vs_valid();
    rst = 1'b1; in_valid = 1'b1; A = 64'h1; B = 64'h1; op_sub = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_wins busy=%b ir=%b exp 0/1", busy, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_wrap();
    test_sub();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_vs_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_multiword_seq.md
Name: cla_multiword_seq

Overview:
Sequencer that performs WORDS×16-bit add/subtract by time-multiplexing one CLA_16 adder slice. It runs least-significant word first and chains the carry through a register. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Status flags are carry-out, signed overflow and zero.

Parameters:
WORDS, 4, number of 16-bit words per operand (total width 16*WORDS); legal range 2..16.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand request valid.
in_ready  out  1  sequencer can accept a request.
op_sub  in  1  0: A+B, 1: A−B; sampled at accept.
A  in  16*WORDS  operand A; sampled at accept.
B  in  16*WORDS  operand B; sampled at accept.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
S  out  16*WORDS  result.
cout  out  1  carry out of MSB; for subtract, 1 means no borrow.
ovf  out  1  signed two's-complement overflow.
zero  out  1  S == 0.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, S=0, cout=0, ovf=0, zero=0, busy=0. Word index, carry register and operand registers are cleared to 0.
- States: IDLE, RUN, DONE. Encoding is 2 bits: IDLE=00, RUN=01, DONE=10. 11 is illegal and goes to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A, B and op_sub; set idx=0; set carry=op_sub; go to RUN.
- RUN:
  - in_ready=0. Each cycle the adder slice sees X=A[idx], Y=B[idx]^{16{op_sub}}, Cin=carry.
  - Slice sum goes to S[idx]; carry←slice Cout; idx←idx+1.
  - When idx==WORDS−1, the final word is written and state goes to DONE.
  - On that same final cycle: cout←slice Cout; ovf←(X[15]==Y[15])&&(sum[15]!=X[15]), using the inverted Y for subtract.
- DONE:
  - out_valid=1; zero reflects the full S.
  - On out_ready: out_valid←0, state←IDLE.
  - S and flags hold until the next accept.
- Latency: accept edge to out_valid high is exactly WORDS+1 cycles (WORDS RUN cycles plus the DONE entry). Throughput is one op per WORDS+2 cycles with out_ready held high.
- Backpressure: with out_ready low in DONE, S, cout, ovf, zero and out_valid stay stable indefinitely. in_valid is ignored there.
- Handshake rules:
  - in_ready is a function of state only; it never depends on in_valid.
  - Changes to A, B or op_sub after accept have no effect on the result.
- S is not guaranteed valid while busy; the bench checks it only when out_valid=1.
- Reset mid-operation (RUN or DONE) returns to IDLE immediately and asynchronously. The partial result is discarded and out_valid drops with no further handshake.
- Simultaneous in_valid and rst: rst wins; the request is not accepted.
- Width rules:
  - idx width is $clog2(WORDS).
  - The carry register is 1 bit and is never carried across operations; it is re-seeded from op_sub at each accept.
- The adder slice is purely combinational; no combinational path from in_* to out_*.

Decomposition:
- Shared include file cla_pkg.vh: WORD_W=16; state localparams ST_IDLE, ST_RUN, ST_DONE.
- Sub-module: existing CLA_16 instantiated once as the datapath slice (ports X, Y, Cin, S, Cout).
- Everything else, including FSM, operand and result registers and flag logic, stays in cla_multiword_seq.

Test Plan:
- Add with cross-word carry, WORDS=4: A=0x00000000FFFFFFFF, B=0x1, op_sub=0 → S=0x0000000100000000, cout=0, ovf=0, zero=0; out_valid exactly 5 cycles after accept.
- Full wrap to zero: A=0xFFFFFFFFFFFFFFFF, B=0x1, op_sub=0 → S=0, cout=1, ovf=0, zero=1.
- Subtract with borrow: A=5, B=7, op_sub=1 → S=0xFFFFFFFFFFFFFFFE, cout=0, ovf=0; then A=7, B=5 → S=2, cout=1.
- Signed overflow: A=0x7FFFFFFFFFFFFFFF, B=1, add → S=0x8000000000000000, ovf=1, cout=0. Also A=0x8000000000000000, B=1, sub → S=0x7FFFFFFFFFFFFFFF, ovf=1, cout=1.
- Backpressure and isolation: hold out_ready=0 for 10 cycles in DONE while changing A/B/in_valid → S and flags unchanged, in_ready=0. Release → IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst on the 2nd RUN cycle → out_valid=0, busy=0, in_ready=1 immediately. A new op A=0xDDDD, B=0x0022 then completes normally with S=0xDDFF, and the prior carry is not leaked.
